// File: rtl/port_ctrl.sv
// port_ctrl: serves one forward/drop tag at a time -- issues a buffer read command, then streams the returned beats.
// Build option PORT_CTRL_OUTREG_EN registers the output beat path through a 2-entry skid buffer.
`ifndef ADDR_LENTH
`define ADDR_LENTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module port_ctrl #(
  parameter int unsigned AW_PKT  = `ADDR_LENTH,
  parameter int unsigned DW_DATA = `DATA_WIDTH
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iTagQueueInVld,
  output logic                iTagQueueInRdy,
  input  logic [AW_PKT+7:0]   iTagQueueInPld,
  input  logic                iTagDropInVld,
  output logic                iTagDropInRdy,
  input  logic [AW_PKT+7:0]   iTagDropInPld,
  output logic                oRdCmdVld,
  input  logic                oRdCmdRdy,
  output logic [AW_PKT+4:0]   oRdCmdPld,
  output logic [3:0]          oRdCmdAddr,
  input  logic                iRdDataVld,
  output logic                iRdDataRdy,
  input  logic [DW_DATA:0]    iRdDataPld,
  input  logic [3:0]          iRdDataAddr,
  output logic                oRdVld,
  output logic [DW_DATA-1:0]  oRdData,
  output logic                oRdSop,
  output logic                oRdEop,
  output logic                oRdLast,
  input  logic                iRdRdy
);

  localparam int unsigned MW = AW_PKT + 4;
  localparam int unsigned TW = AW_PKT + 8;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} stateT;

  stateT              state;
  stateT              nextState;
  logic [MW-1:0]      tagMsg;
  logic [3:0]         tagSrc;
  logic               tagDrop;
  logic               sopPend;
  logic               rdLastQ;

  logic               dropRdy;
  logic               queueRdy;
  logic               cmdVld;
  logic               tagAccept;
  logic               cmdFire;
  logic               inRdy;
  logic               inFire;
  logic               inLast;
  logic [DW_DATA-1:0] inData;
  logic               outVld;
  logic               outFire;
  logic               outSop;
  logic               outEop;
  logic [DW_DATA-1:0] outData;

  // Beats carry no routing information back; the address field is ignored.
  logic unusedRdAddr;
  assign unusedRdAddr = ^iRdDataAddr;

  assign inData    = iRdDataPld[DW_DATA:1];
  assign inLast    = iRdDataPld[0];
  assign inFire    = inRdy && iRdDataVld;
  assign outFire   = outVld && iRdRdy;
  assign tagAccept = (dropRdy && iTagDropInVld) || (queueRdy && iTagQueueInVld);
  assign cmdFire   = cmdVld && oRdCmdRdy;

  // Next state and tag/command handshakes; everything forced low while reset is held.
  always_comb begin
    nextState = state;
    dropRdy   = 1'b0;
    queueRdy  = 1'b0;
    cmdVld    = 1'b0;
    case (state)
      IDLE: begin
        dropRdy  = 1'b1;
        queueRdy = !iTagDropInVld;
        if (iTagDropInVld || iTagQueueInVld) nextState = CMD;
      end
      CMD: begin
        cmdVld = 1'b1;
        if (oRdCmdRdy) nextState = tagDrop ? IDLE : DATA;
      end
      DATA: begin
        if (outFire && outEop) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (!iRst_n) begin
      dropRdy  = 1'b0;
      queueRdy = 1'b0;
      cmdVld   = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= IDLE;
      tagMsg  <= '0;
      tagSrc  <= '0;
      tagDrop <= 1'b0;
      sopPend <= 1'b0;
      rdLastQ <= 1'b0;
    end else begin
      state <= nextState;
      if (tagAccept) begin
        if (iTagDropInVld) begin
          tagMsg  <= iTagDropInPld[TW-1:4];
          tagSrc  <= iTagDropInPld[3:0];
          tagDrop <= 1'b1;
        end else begin
          tagMsg  <= iTagQueueInPld[TW-1:4];
          tagSrc  <= iTagQueueInPld[3:0];
          tagDrop <= 1'b0;
        end
      end
      // Sop marks the first beat taken from the buffer for this packet.
      if (cmdFire && !tagDrop) sopPend <= 1'b1;
      else if (inFire)         sopPend <= 1'b0;
      rdLastQ <= outFire && outEop;
    end
  end

`ifdef PORT_CTRL_OUTREG_EN
  localparam int unsigned BW = DW_DATA + 2;

  logic [BW-1:0] skidMem [2];
  logic          wrPtr;
  logic          rdPtr;
  logic [1:0]    skidCnt;
  logic          gotLast;

  // Input ready depends only on buffer space; once the last beat is buffered, stop taking beats.
  assign inRdy  = (state == DATA) && !gotLast && (skidCnt != 2'd2) && iRst_n;
  assign outVld = (skidCnt != 2'd0) && iRst_n;
  assign {outSop, outEop, outData} = skidMem[rdPtr];

  always_ff @(posedge iClk) begin
    if (inFire) skidMem[wrPtr] <= {sopPend, inLast, inData};
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      skidCnt <= 2'd0;
      gotLast <= 1'b0;
    end else begin
      if (inFire)  wrPtr <= !wrPtr;
      if (outFire) rdPtr <= !rdPtr;
      skidCnt <= 2'(skidCnt + 2'(inFire) - 2'(outFire));
      if (state != DATA)          gotLast <= 1'b0;
      else if (inFire && inLast)  gotLast <= 1'b1;
    end
  end
`else
  assign inRdy   = (state == DATA) && iRdRdy && iRst_n;
  assign outVld  = (state == DATA) && iRdDataVld && iRst_n;
  assign outData = inData;
  assign outSop  = sopPend;
  assign outEop  = inLast;
`endif

  assign iTagDropInRdy  = dropRdy;
  assign iTagQueueInRdy = queueRdy;
  assign oRdCmdVld      = cmdVld;
  assign oRdCmdPld      = iRst_n ? {tagMsg, tagDrop} : '0;
  assign oRdCmdAddr     = iRst_n ? tagSrc : 4'd0;
  assign iRdDataRdy     = inRdy;
  assign oRdVld         = outVld;
  assign oRdData        = outVld ? outData : '0;
  assign oRdSop         = outVld && outSop;
  assign oRdEop         = outVld && outEop;
  assign oRdLast        = rdLastQ && iRst_n;

endmodule

// File: tb/tb_port_ctrl.sv
// Directed bench for port_ctrl: table-driven tag/command vectors plus hand-written packet, drop and reset sequences.
module tb_port_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = AW + 8;
  localparam int unsigned CW = AW + 5;
  localparam int          NV = 11;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iTagQueueInVld, iTagQueueInRdy;
  logic [TW-1:0] iTagQueueInPld;
  logic          iTagDropInVld, iTagDropInRdy;
  logic [TW-1:0] iTagDropInPld;
  logic          oRdCmdVld, oRdCmdRdy;
  logic [CW-1:0] oRdCmdPld;
  logic [3:0]    oRdCmdAddr;
  logic          iRdDataVld, iRdDataRdy;
  logic [DW:0]   iRdDataPld;
  logic [3:0]    iRdDataAddr;
  logic          oRdVld;
  logic [DW-1:0] oRdData;
  logic          oRdSop, oRdEop, oRdLast;
  logic          iRdRdy;

  port_ctrl #(.AW_PKT(AW), .DW_DATA(DW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iTagQueueInVld(iTagQueueInVld), .iTagQueueInRdy(iTagQueueInRdy), .iTagQueueInPld(iTagQueueInPld),
    .iTagDropInVld(iTagDropInVld), .iTagDropInRdy(iTagDropInRdy), .iTagDropInPld(iTagDropInPld),
    .oRdCmdVld(oRdCmdVld), .oRdCmdRdy(oRdCmdRdy), .oRdCmdPld(oRdCmdPld), .oRdCmdAddr(oRdCmdAddr),
    .iRdDataVld(iRdDataVld), .iRdDataRdy(iRdDataRdy), .iRdDataPld(iRdDataPld), .iRdDataAddr(iRdDataAddr),
    .oRdVld(oRdVld), .oRdData(oRdData), .oRdSop(oRdSop), .oRdEop(oRdEop), .oRdLast(oRdLast),
    .iRdRdy(iRdRdy)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic          dropVld;
    logic [TW-1:0] dropPld;
    logic          queueVld;
    logic [TW-1:0] queuePld;
    logic          cmdRdy;
    logic          eDropRdy;
    logic          eQueueRdy;
    logic          eCmdVld;
    logic [CW-1:0] eCmdPld;
    logic [3:0]    eCmdAddr;
    logic          eDataRdy;
  } vecT;

  vecT           tbl [NV];
  int            nVec = 0;
  int            nMis = 0;
  logic [DW+1:0] beatQ [$];
  int            lastCnt = 0;
  int            lastErr = 0;
  logic          lastExp = 1'b0;
  bit            rdyRand = 1'b0;
  int            rdyCnt = 0;

  function automatic logic [TW-1:0] tagPld(input int msg, input int src);
    return (TW'(msg) << 4) | TW'(src & 15);
  endfunction

  function automatic vecT mkVec(input logic dv, input logic [TW-1:0] dp, input logic qv,
                                input logic [TW-1:0] qp, input logic cr, input logic edr,
                                input logic eqr, input logic ecv, input logic [CW-1:0] ep,
                                input logic [3:0] ea, input logic edtr);
    vecT v;
    v.dropVld = dv; v.dropPld = dp; v.queueVld = qv; v.queuePld = qp; v.cmdRdy = cr;
    v.eDropRdy = edr; v.eQueueRdy = eqr; v.eCmdVld = ecv; v.eCmdPld = ep; v.eCmdAddr = ea;
    v.eDataRdy = edtr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nMis++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Output monitor: collects accepted beats, checks oRdLast lands one cycle after the Eop handshake.
  initial begin
    forever begin
      @(negedge iClk);
      if (oRdLast !== lastExp) lastErr++;
      if (oRdLast === 1'b1) lastCnt++;
      lastExp = oRdVld && iRdRdy && oRdEop;
      if (oRdVld && iRdRdy) beatQ.push_back({oRdSop, oRdEop, oRdData});
    end
  end

  // Downstream ready: held high, or toggled at random 0-9 cycle intervals.
  initial begin
    iRdRdy = 1'b1;
    forever begin
      @(posedge iClk); #1;
      if (rdyRand) begin
        if (rdyCnt == 0) begin
          iRdRdy = ~iRdRdy;
          rdyCnt = int'($urandom_range(0, 9));
        end else begin
          rdyCnt--;
        end
      end else begin
        iRdRdy = 1'b1;
      end
    end
  end

  task automatic applyReset(input int cycles);
    @(posedge iClk); #1;
    iRst_n     = 1'b0;
    iRdDataVld = 1'b1;
    iRdDataPld = {DW'(32'h5A5A_0001), 1'b1};
    for (int c = 0; c < cycles; c++) begin
      @(negedge iClk);
      check("reset ctl", 64'({iTagDropInRdy, iTagQueueInRdy, oRdCmdVld, iRdDataRdy,
                              oRdVld, oRdSop, oRdEop, oRdLast}), 64'd0);
      check("reset cmd", 64'({oRdCmdPld, oRdCmdAddr}), 64'd0);
      check("reset data", 64'(oRdData), 64'd0);
      @(posedge iClk); #1;
    end
    iRdDataVld = 1'b0;
    iRst_n     = 1'b1;
  endtask

  task automatic issueTag(input bit isDrop, input int src, input int msg, input int expPld,
                          input int expAddr);
    logic [TW-1:0] pld = tagPld(msg, src);
    int            budget = 20;
    bit            acc = 1'b0;
    @(posedge iClk); #1;
    if (isDrop) begin iTagDropInVld = 1'b1; iTagDropInPld = pld; end
    else        begin iTagQueueInVld = 1'b1; iTagQueueInPld = pld; end
    while (!acc && budget > 0) begin
      @(negedge iClk);
      acc = isDrop ? iTagDropInRdy : iTagQueueInRdy;
      budget--;
      @(posedge iClk); #1;
    end
    iTagDropInVld  = 1'b0;
    iTagQueueInVld = 1'b0;
    oRdCmdRdy      = 1'b1;
    if (!acc) timeoutFail("tag accept");
    @(negedge iClk);
    check("cmd vld", 64'(oRdCmdVld), 64'd1);
    check("cmd pld", 64'(oRdCmdPld), 64'(expPld));
    check("cmd addr", 64'(oRdCmdAddr), 64'(expAddr));
    @(posedge iClk); #1;
    oRdCmdRdy = 1'b0;
    if (isDrop) begin
      @(negedge iClk);
      check("queue rdy after drop", 64'(iTagQueueInRdy), 64'd1);
    end
  endtask

  task automatic sendBeats(input int n, input int base, input int abortAt);
    int i = 0;
    int budget = 400;
    while (i < n) begin
      @(posedge iClk); #1;
      if (abortAt >= 0 && beatQ.size() >= abortAt) begin
        iRdDataVld = 1'b0;
        return;
      end
      iRdDataVld = 1'b1;
      iRdDataPld = {DW'(base + i), (i == n - 1)};
      @(negedge iClk);
      if (iRdDataRdy) i++;
      budget--;
      if (budget == 0) begin
        timeoutFail("beat send");
        iRdDataVld = 1'b0;
        return;
      end
    end
    @(posedge iClk); #1;
    iRdDataVld = 1'b0;
  endtask

  task automatic waitLast(input string tag, input int l0);
    int b = 0;
    while (lastCnt == l0 && b < 60) begin
      @(posedge iClk);
      b++;
    end
    if (lastCnt == l0) timeoutFail({tag, " last pulse"});
    @(posedge iClk); @(posedge iClk);
    check({tag, " last pulses"}, 64'(lastCnt - l0), 64'd1);
    check({tag, " last timing errs"}, 64'(lastErr), 64'd0);
    @(negedge iClk);
    check({tag, " idle"}, 64'(iTagDropInRdy), 64'd1);
  endtask

  task automatic checkBeats(input string tag, input int nSeen, input int nTot, input int base);
    check({tag, " beat count"}, 64'(beatQ.size()), 64'(nSeen));
    for (int i = 0; i < nSeen && i < beatQ.size(); i++)
      check({tag, " beat"}, 64'(beatQ[i]), 64'({(i == 0), (i == nTot - 1), DW'(base + i)}));
  endtask

  initial begin
    int l0;
    int qAt;
    iRst_n = 1'b0;
    iTagQueueInVld = 1'b0; iTagQueueInPld = '0;
    iTagDropInVld = 1'b0;  iTagDropInPld = '0;
    oRdCmdRdy = 1'b0;
    iRdDataVld = 1'b0; iRdDataPld = '0; iRdDataAddr = 4'h0;

    tbl[0]  = mkVec(0, '0,            0, '0,           0, 1, 1, 0, 21'd0,  4'd0, 0);
    tbl[1]  = mkVec(1, tagPld(9, 8),  1, tagPld(3, 2), 1, 1, 0, 0, 21'd0,  4'd0, 0);
    tbl[2]  = mkVec(0, '0,            1, tagPld(3, 2), 1, 0, 0, 1, 21'd19, 4'd8, 0);
    tbl[3]  = mkVec(0, '0,            1, tagPld(3, 2), 0, 1, 1, 0, 21'd0,  4'd0, 0);
    tbl[4]  = mkVec(0, '0,            0, '0,           0, 0, 0, 1, 21'd6,  4'd2, 0);
    for (int k = 5; k <= 8; k++)
      tbl[k] = mkVec(1, tagPld(1, 1), 0, '0,           0, 0, 0, 1, 21'd6,  4'd2, 0);
    tbl[9]  = mkVec(1, tagPld(1, 1),  0, '0,           1, 0, 0, 1, 21'd6,  4'd2, 0);
    tbl[10] = mkVec(1, tagPld(1, 1),  0, '0,           0, 0, 0, 0, 21'd0,  4'd0, 1);

    applyReset(3);

    // Drop/queue priority, command hold under backpressure, no tag taken while busy.
    for (int v = 0; v < NV; v++) begin
      @(posedge iClk); #1;
      iTagDropInVld  = tbl[v].dropVld;
      iTagDropInPld  = tbl[v].dropPld;
      iTagQueueInVld = tbl[v].queueVld;
      iTagQueueInPld = tbl[v].queuePld;
      oRdCmdRdy      = tbl[v].cmdRdy;
      @(negedge iClk);
      check($sformatf("v%0d dropRdy", v), 64'(iTagDropInRdy), 64'(tbl[v].eDropRdy));
      check($sformatf("v%0d queueRdy", v), 64'(iTagQueueInRdy), 64'(tbl[v].eQueueRdy));
      check($sformatf("v%0d cmdVld", v), 64'(oRdCmdVld), 64'(tbl[v].eCmdVld));
      check($sformatf("v%0d dataRdy", v), 64'(iRdDataRdy), 64'(tbl[v].eDataRdy));
      if (tbl[v].eCmdVld) begin
        check($sformatf("v%0d cmdPld", v), 64'(oRdCmdPld), 64'(tbl[v].eCmdPld));
        check($sformatf("v%0d cmdAddr", v), 64'(oRdCmdAddr), 64'(tbl[v].eCmdAddr));
      end
    end
    @(posedge iClk); #1;
    iTagDropInVld = 1'b0;
    oRdCmdRdy     = 1'b0;

    // Single-beat packet for the queued src=2 tag: Sop and Eop together.
    beatQ.delete();
    l0 = lastCnt;
    sendBeats(1, 32'hAB, -1);
    waitLast("one-beat", l0);
    checkBeats("one-beat", 1, 1, 32'hAB);

    // Queue tag src=3 msg=4, nine beats at full rate.
    issueTag(1'b0, 3, 4, 8, 3);
    beatQ.delete();
    l0 = lastCnt;
    sendBeats(9, 0, -1);
    waitLast("pkt9", l0);
    checkBeats("pkt9", 9, 9, 0);

    // Drop tag src=8 msg=9: command only, offered beats are not consumed.
    beatQ.delete();
    issueTag(1'b1, 8, 9, 19, 8);
    @(posedge iClk); #1;
    iRdDataVld = 1'b1;
    iRdDataPld = {DW'(32'hDEAD), 1'b1};
    for (int c = 0; c < 4; c++) begin
      @(negedge iClk);
      check("drop dataRdy", 64'(iRdDataRdy), 64'd0);
    end
    @(posedge iClk); #1;
    iRdDataVld = 1'b0;
    check("drop beats", 64'(beatQ.size()), 64'd0);

    // Nine beats under random downstream backpressure.
    issueTag(1'b0, 3, 4, 8, 3);
    beatQ.delete();
    l0 = lastCnt;
    rdyRand = 1'b1;
    sendBeats(9, 0, -1);
    waitLast("backpressure", l0);
    rdyRand = 1'b0;
    checkBeats("backpressure", 9, 9, 0);

    // Reset after beat 3 abandons the packet; the next tag is served normally.
    issueTag(1'b0, 1, 2, 4, 1);
    beatQ.delete();
    sendBeats(9, 0, 4);
    checkBeats("pre-reset", 4, 9, 0);
    l0 = lastCnt;
    qAt = beatQ.size();
    applyReset(5);
    repeat (4) @(posedge iClk);
    check("post-reset beats", 64'(beatQ.size()), 64'(qAt));
    check("post-reset last", 64'(lastCnt - l0), 64'd0);
    @(negedge iClk);
    check("post-reset idle", 64'(iTagDropInRdy), 64'd1);
    issueTag(1'b0, 5, 7, 14, 5);
    beatQ.delete();
    l0 = lastCnt;
    sendBeats(3, 100, -1);
    waitLast("after-reset", l0);
    checkBeats("after-reset", 3, 3, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
